// File: rtl/alu_operand_sequencer.sv
// Steps a push-button through A, B and opcode entry to present a committed ALU operand set.
// Optional SEQ_ACCUMULATE_EN: pressing in READY loads the ALU result into A and chains.
module alu_operand_sequencer #(
    parameter int unsigned DEBOUNCE_CYCLES = 500000
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       key_n,
    input  logic [3:0] sw,
    input  logic [3:0] result,
    output logic [3:0] a,
    output logic [3:0] b,
    output logic [1:0] alucontrol,
    output logic       valid,
    output logic       strobe,
    output logic [1:0] phase
);

    localparam int unsigned CntW = $clog2(DEBOUNCE_CYCLES + 1);
    localparam logic [CntW-1:0] CntLast = CntW'(DEBOUNCE_CYCLES - 1);

    typedef enum logic [1:0] {
        StEnterA  = 2'b00,
        StEnterB  = 2'b01,
        StEnterOp = 2'b10,
        StReady   = 2'b11
    } state_e;

    logic [1:0]      sync_q;
    logic            deb_q;
    logic            deb_dly_q;
    logic            press_q;
    logic [CntW-1:0] cnt_q;

    state_e     state_q, state_d;
    logic [3:0] a_q, a_d;
    logic [3:0] b_q, b_d;
    logic [1:0] op_q, op_d;
    logic       valid_q;
    logic       strobe_q, strobe_d;

    // sync_q[1] is the synchronized key level; the press pulse is registered once more
    // so operand fields update DEBOUNCE_CYCLES+3 edges after the first low sample.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_q    <= 2'b11;
            deb_q     <= 1'b1;
            deb_dly_q <= 1'b1;
            press_q   <= 1'b0;
            cnt_q     <= '0;
        end else begin
            sync_q    <= {sync_q[0], key_n};
            deb_dly_q <= deb_q;
            press_q   <= deb_dly_q & ~deb_q;
            if (sync_q[1] == deb_q) begin
                cnt_q <= '0;
            end else if (cnt_q == CntLast) begin
                cnt_q <= '0;
                deb_q <= sync_q[1];
            end else begin
                cnt_q <= cnt_q + CntW'(1);
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= StEnterA;
            a_q      <= '0;
            b_q      <= '0;
            op_q     <= '0;
            valid_q  <= 1'b0;
            strobe_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            a_q      <= a_d;
            b_q      <= b_d;
            op_q     <= op_d;
            valid_q  <= (state_d == StReady);
            strobe_q <= strobe_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        a_d      = a_q;
        b_d      = b_q;
        op_d     = op_q;
        strobe_d = 1'b0;
        if (press_q) begin
            unique case (state_q)
                StEnterA: begin
                    a_d     = sw;
                    state_d = StEnterB;
                end
                StEnterB: begin
                    b_d     = sw;
                    state_d = StEnterOp;
                end
                StEnterOp: begin
                    op_d     = sw[1:0];
                    state_d  = StReady;
                    strobe_d = 1'b1;
                end
                StReady: begin
`ifdef SEQ_ACCUMULATE_EN
                    a_d     = result;
                    state_d = StEnterB;
`else
                    state_d = StEnterA;
`endif
                end
            endcase
        end
    end

`ifndef SEQ_ACCUMULATE_EN
    logic unused_result;
    assign unused_result = ^result;
`endif

    assign a          = a_q;
    assign b          = b_q;
    assign alucontrol = op_q;
    assign valid      = valid_q;
    assign strobe     = strobe_q;
    assign phase      = state_q;

endmodule

// File: tb/tb_alu_operand_sequencer.sv
// Bench for alu_operand_sequencer (default build): directed and random key presses and
// glitches checked against a press-count reference model with fixed debounce latency.
module tb_alu_operand_sequencer;

    localparam int unsigned D = 4;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       key_n;
    logic [3:0] sw;
    logic [3:0] result;
    logic [3:0] a;
    logic [3:0] b;
    logic [1:0] alucontrol;
    logic       valid;
    logic       strobe;
    logic [1:0] phase;

    int vectors = 0;
    int miscompares = 0;

    // Reference: fields entered so far and number of presses taken in the current round.
    logic [3:0] m_a, m_b;
    logic [1:0] m_op;
    int         m_step;

    always #5 clk = ~clk;

    alu_operand_sequencer #(.DEBOUNCE_CYCLES(D)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .key_n      (key_n),
        .sw         (sw),
        .result     (result),
        .a          (a),
        .b          (b),
        .alucontrol (alucontrol),
        .valid      (valid),
        .strobe     (strobe),
        .phase      (phase)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic check_all(input string tag, input logic exp_strobe);
        chk({tag, ".a"}, 32'(a), 32'(m_a));
        chk({tag, ".b"}, 32'(b), 32'(m_b));
        chk({tag, ".op"}, 32'(alucontrol), 32'(m_op));
        chk({tag, ".phase"}, 32'(phase), 32'(m_step));
        chk({tag, ".valid"}, 32'(valid), 32'(m_step == 3));
        chk({tag, ".strobe"}, 32'(strobe), 32'(exp_strobe));
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic model_reset();
        m_a    = '0;
        m_b    = '0;
        m_op   = '0;
        m_step = 0;
    endtask

    task automatic model_event(input logic [3:0] v);
        case (m_step)
            0: m_a = v;
            1: m_b = v;
            2: m_op = v[1:0];
            default: ;
        endcase
        m_step = (m_step + 1) % 4;
    endtask

    // key_n is already low and the next rising edge is the first to sample it.
    task automatic await_event(input logic [3:0] v, input int hold, input string tag);
        int prev;
        repeat (D + 3) @(posedge clk);
        #1;
        check_all({tag, ".pre"}, 1'b0);
        prev = m_step;
        model_event(v);
        tick();
        check_all({tag, ".upd"}, prev == 2);
        sw = 4'hF;
        tick();
        check_all({tag, ".post"}, 1'b0);
        repeat (hold) tick();
        key_n = 1'b1;
        repeat (D + 6) tick();
        check_all({tag, ".rel"}, 1'b0);
    endtask

    task automatic press(input logic [3:0] v, input int hold, input string tag);
        sw    = v;
        key_n = 1'b0;
        await_event(v, hold, tag);
    endtask

    task automatic glitch(input int len, input string tag);
        key_n = 1'b0;
        repeat (len) tick();
        key_n = 1'b1;
        sw = 4'($urandom);
        repeat (D + 6) tick();
        check_all(tag, 1'b0);
    endtask

    initial begin
        logic [3:0] v;
        rst_n  = 1'b0;
        key_n  = 1'b1;
        sw     = '0;
        result = '0;
        model_reset();
        repeat (3) tick();
        check_all("reset", 1'b0);
        rst_n = 1'b1;
        repeat (2) tick();

        for (int i = 0; i < 5; i++) glitch(D - 1, "short_pulse");

        press(4'h4, 0, "seq_a");
        press(4'h4, 0, "seq_b");
        press(4'h0, 0, "seq_op");
        press(4'h9, 0, "wrap");

        press(4'h3, 100, "long_hold");
        press(4'hD, 0, "ret_b");
        press(4'h1, 0, "ret_op");
        press(4'h7, 0, "ret_wrap");

        for (int i = 0; i < 40; i++) begin
            result = 4'($urandom);
            if ($urandom_range(0, 3) == 0) begin
                glitch(int'($urandom_range(1, D - 1)), "rnd_glitch");
            end else begin
                press(4'($urandom), int'($urandom_range(0, 5)), "rnd_press");
            end
        end

        while (m_step != 2) press(4'($urandom), 0, "to_op");
        v     = 4'($urandom);
        sw    = v;
        key_n = 1'b0;
        repeat (2) tick();
        rst_n = 1'b0;
        #1;
        model_reset();
        check_all("rst_async", 1'b0);
        tick();
        check_all("rst_hold", 1'b0);
        rst_n = 1'b1;
        await_event(v, 2, "rst_rel");

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/alu_operand_sequencer.md
ALU_OPERAND_SEQUENCER -- requirements
Module: alu_operand_sequencer

Interface
REQ-001 Parameter: DEBOUNCE_CYCLES, default 500000, number of consecutive clk cycles a synchronized key level must be stable before acceptance (10 ms at 50 MHz); legal range 1..2^20.
REQ-002 Port: clk  in  1  single system clock, all state on rising edge.
REQ-003 Port: rst_n  in  1  reset, asynchronous, active-low.
REQ-004 Port: key_n  in  1  step push-button, active-low, asynchronous to clk, bouncing.
REQ-005 Port: sw  in  4  operand/opcode value from slide switches.
REQ-006 Port: result  in  4  ALU result fed back from the downstream ALU; used only when SEQ_ACCUMULATE_EN is defined.
REQ-007 Port: a  out  4  operand A to ALU.
REQ-008 Port: b  out  4  operand B to ALU.
REQ-009 Port: alucontrol  out  2  ALU opcode.
REQ-010 Port: valid  out  1  high while all three fields are committed (READY).
REQ-011 Port: strobe  out  1  one-cycle pulse on the cycle READY is entered.
REQ-012 Port: phase  out  2  state: 00 ENTER_A, 01 ENTER_B, 10 ENTER_OP, 11 READY.

Function
REQ-013 key_n SHALL pass a 2-flop synchronizer before any other use.
REQ-014 Debouncer SHALL count consecutive cycles the synchronized level differs from the debounced level; counter clears when they match; debounced level toggles when count reaches DEBOUNCE_CYCLES.
REQ-015 A press event SHALL be a single-cycle pulse on debounced 1->0 transition; release generates no event; holding the key generates exactly one event.
REQ-016 Pulses shorter than DEBOUNCE_CYCLES cycles SHALL produce no event and no state change.
REQ-017 Latency: first clk edge sampling key_n low at edge 0 -> a/b/alucontrol/phase update at edge DEBOUNCE_CYCLES+3, given key_n stays low.
REQ-018 ENTER_A + event: a <= sw, -> ENTER_B.
REQ-019 ENTER_B + event: b <= sw, -> ENTER_OP.
REQ-020 ENTER_OP + event: alucontrol <= sw[1:0], -> READY, strobe=1 for that one cycle after the edge.
REQ-021 READY + event (macro undefined): -> ENTER_A; a, b, alucontrol hold until overwritten.
REQ-022 valid SHALL equal (phase==11), registered, no combinational path from any input.
REQ-023 sw changes without an event SHALL never alter a, b, alucontrol.
REQ-024 States not listed SHALL not exist; phase encoding is the state register itself.

Reset
REQ-025 rst_n low SHALL immediately clear a, b, alucontrol, strobe, valid to 0, phase to 00, synchronizer flops and debounced level to 1, counter to 0.
REQ-026 Reset asserted mid-press or mid-sequence SHALL abandon the sequence; after release a key still held low SHALL produce one event after full debounce.

Configuration
REQ-027 Macro SEQ_ACCUMULATE_EN: when defined, READY + event SHALL set a <= result and go to ENTER_B (chained operations), strobe not asserted on that transition; when undefined, REQ-021 applies and result is unused.

Verification (DEBOUNCE_CYCLES=4)
REQ-028 Reset then sw=4, press; sw=4, press; sw=0, press -> a=4, b=4, alucontrol=00, phase=11, valid=1, strobe exactly one cycle, each update at edge 7 after press.
REQ-029 key_n low 3 cycles then high, repeated 5 times -> no event, phase stays 00, a=0.
REQ-030 key_n held low 100 cycles after sw=3 -> exactly one event, a=3, phase=01; sw toggled to F during hold -> a stays 3.
REQ-031 Sequence A=3,B=D,op=01 reaching READY, press (macro undefined) -> phase=00, valid=0, a=3, b=D, alucontrol=01 retained.
REQ-032 Macro defined, READY with result=9, press -> a=9, phase=01, strobe stays 0; then b=2, op=10 -> READY, strobe one pulse.
REQ-033 rst_n pulsed low while phase=10 -> all outputs 0 within same cycle, phase=00; held key after release -> one event, a=sw.
